// File: rtl/usr_ctrl_pkg.sv
// ============================================================================
// Module   : usr_ctrl_pkg
// Purpose  : Shared definitions for the universal-shift-register serializer.
//            The select codes drive usr_ctrl_shreg, and the state enum is used
//            by the usr_serial_ctrl sequencer.
// Contents : SEL_HOLD / SEL_SHR / SEL_SHL / SEL_LOAD (2-bit select codes),
//            state_t {IDLE, SHIFT, PARITY}
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/usr_serial_ctrl_if.sv
// ============================================================================
// Module   : usr_serial_ctrl_if
// Purpose  : Bundles the word-side and serial-side handshakes of the
//            serializer.
// Signals  : in_data/in_valid/in_ready/cfg_msb_first  - parallel word input
//            s_dout/s_valid/s_ready                   - serial bit output
//            frame_done/busy                          - status
// Modports : slave  - controller view
//            master - producer/consumer (environment) view
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usr_serial_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             cfg_msb_first;
    logic             s_dout;
    logic             s_valid;
    logic             s_ready;
    logic             frame_done;
    logic             busy;

    modport slave (
        input  in_data, in_valid, cfg_msb_first, s_ready,
        output in_ready, s_dout, s_valid, frame_done, busy
    );

    modport master (
        output in_data, in_valid, cfg_msb_first, s_ready,
        input  in_ready, s_dout, s_valid, frame_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/usr_ctrl_shreg.sv
// ============================================================================
// Module   : usr_ctrl_shreg
// Purpose  : Parameterised universal shift register
//            (hold / shift-right / shift-left / parallel-load).
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_sel         - select code (see usr_ctrl_pkg)
//            i_p_din       - parallel load data
//            i_ser_r       - bit entering the MSB on shift-right
//            i_ser_l       - bit entering the LSB on shift-left
//            o_q           - parallel register contents
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_ctrl_shreg
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [1:0]       i_sel,
    input  wire logic [WIDTH-1:0] i_p_din,
    input  wire logic             i_ser_r,
    input  wire logic             i_ser_l,
    output      logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            case (i_sel)
                SEL_SHR:  r_q <= {i_ser_r, r_q[WIDTH-1:1]};
                SEL_SHL:  r_q <= {r_q[WIDTH-2:0], i_ser_l};
                SEL_LOAD: r_q <= i_p_din;
                default:  r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/usr_serial_ctrl.sv
// ============================================================================
// Module   : usr_serial_ctrl
// Purpose  : Accepts parallel words over a valid/ready handshake, loads them
//            into an embedded universal shift register and shifts them out
//            one bit per accepted serial beat, MSB- or LSB-first per frame.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - usr_serial_ctrl_if.slave (word input, serial output,
//                       frame_done pulse, busy)
// Options  : USR_SERIAL_PARITY_EN - when defined, an even-parity bit of the
//            word follows the data bits and frame_done moves to that bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_serial_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    usr_serial_ctrl_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_in_ready;
    logic             r_s_valid;
    logic             r_busy;
`ifdef USR_SERIAL_PARITY_EN
    logic             r_parity;
`endif

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_q;
    logic             w_word_acc;
    logic             w_bit_acc;
    logic             w_last;
    logic             w_dout;
    logic             w_frame_done;

    assign w_word_acc = bus.in_valid & r_in_ready;
    assign w_bit_acc  = (r_state == SHIFT) & bus.s_ready;
    assign w_last     = w_bit_acc & (r_cnt == c_LAST);

    // Zero fill in both directions leaves the register cleared after a frame.
    usr_ctrl_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_sel   (w_sel),
        .i_p_din (bus.in_data),
        .i_ser_r (1'b0),
        .i_ser_l (1'b0),
        .o_q     (w_q)
    );

    always_comb begin
        w_sel = SEL_HOLD;
        if (w_word_acc) begin
            w_sel = SEL_LOAD;
        end else if (w_bit_acc) begin
            w_sel = r_dir ? SEL_SHL : SEL_SHR;
        end
    end

    always_comb begin
        w_dout = 1'b0;
        case (r_state)
            SHIFT:   w_dout = r_dir ? w_q[WIDTH-1] : w_q[0];
`ifdef USR_SERIAL_PARITY_EN
            PARITY:  w_dout = r_parity;
`endif
            default: w_dout = 1'b0;
        endcase
    end

`ifdef USR_SERIAL_PARITY_EN
    assign w_frame_done = (r_state == PARITY) & bus.s_ready;
`else
    assign w_frame_done = w_last;
`endif

    // Sequencer; handshake/status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_in_ready <= 1'b1;
            r_s_valid  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef USR_SERIAL_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_word_acc) begin
                        r_state    <= SHIFT;
                        r_cnt      <= '0;
                        r_dir      <= bus.cfg_msb_first;
                        r_in_ready <= 1'b0;
                        r_s_valid  <= 1'b1;
                        r_busy     <= 1'b1;
`ifdef USR_SERIAL_PARITY_EN
                        r_parity   <= ^bus.in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_cnt <= '0;
`ifdef USR_SERIAL_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_s_valid  <= 1'b0;
                        r_busy     <= 1'b0;
`endif
                    end else if (w_bit_acc) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef USR_SERIAL_PARITY_EN
                PARITY: begin
                    if (bus.s_ready) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_s_valid  <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_s_valid  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.s_valid    = r_s_valid;
    assign bus.busy       = r_busy;
    assign bus.s_dout     = w_dout;
    assign bus.frame_done = w_frame_done;

endmodule

`default_nettype wire
